y86_dmem_responder: RTL and testbench

- Data-memory responder at the far end of the pipeline memory stage's request interface.
- Accepts one read or write request at a time over a valid/ready handshake and waits a fixed, parameterised latency.
- Bounds-checks the word address, performs the access, then returns read data, an error flag and a Y86 status code over a valid/ready response channel.
- Replaces the memory stage's zero-latency in-place array, so the stage can stall on a realistic memory.

---
 rtl/y86_mem_pkg.sv | 33 +++
 rtl/y86_dmem_array.sv | 46 ++++
 rtl/y86_dmem_responder.sv | 132 +++++++++++++
 tb/tb_y86_dmem_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : y86_mem_pkg
// Purpose : Shared Y86 status codes, responder FSM encoding and request type
//           for the data-memory responder.
// Rev     : 1.0  initial release
// ============================================================================
package y86_mem_pkg;

    localparam logic [2:0] STAT_AOK = 3'b000;
    localparam logic [2:0] STAT_HLT = 3'b100;
    localparam logic [2:0] STAT_ADR = 3'b010;
    localparam logic [2:0] STAT_INS = 3'b001;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int DMEM_DEPTH_DEFAULT = 4096;

    typedef struct packed {
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
    } dmem_req_t;

    // Full 64-bit unsigned compare so high address bits can never alias into range.
    function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned depth);
        return addr < 64'(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/y86_dmem_array.sv
`default_nettype none
// ============================================================================
// Module  : y86_dmem_array
// Purpose : Single-port DEPTH x 64 storage, synchronous write, registered read,
//           preloaded with data[i] = i + 1.
// Rev     : 1.0  initial release
// ============================================================================
module y86_dmem_array #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [63:0]   wdata_i,
    output logic [63:0]   rdata_o
);

    typedef logic [63:0] mem_t [DEPTH];

    function automatic mem_t init_image();
        mem_t img;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = 64'(i + 1);
        end
        return img;
    endfunction

    // Contents come from the load image only; reset deliberately leaves them alone.
    mem_t        mem_q = init_image();
    logic [63:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/y86_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : y86_dmem_responder
// Purpose : Fixed-latency data-memory responder with valid/ready request and
//           response channels, bounds checking and Y86 status reporting.
// Rev     : 1.0  initial release
// ============================================================================
module y86_dmem_responder
    import y86_mem_pkg::*;
#(
    parameter int DEPTH   = DMEM_DEPTH_DEFAULT,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [2:0]  resp_stat
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        req_q, req_d;
    logic             err_q, err_d;
    logic [2:0]       stat_q, stat_d;
    logic             rd_ok_q, rd_ok_d;

    logic             in_range;
    logic             exec;
    logic             arr_we;
    logic             arr_re;
    logic [63:0]      arr_rdata;

    assign in_range = addr_in_range(req_q.addr, DEPTH);

    // The access fires on the last WAIT edge; flush and reset both veto it.
    assign exec   = rst_n && (state_q == ST_WAIT) && (cnt_q == '0) && !flush;
    assign arr_we = exec && in_range && req_q.write;
    assign arr_re = exec && in_range && !req_q.write;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        err_d   = err_q;
        stat_d  = stat_q;
        rd_ok_d = rd_ok_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    state_d     = ST_WAIT;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    req_d.write = req_write;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    err_d   = !in_range;
                    stat_d  = in_range ? STAT_AOK : STAT_ADR;
                    rd_ok_d = in_range && !req_q.write;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (flush || resp_ready) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                    stat_d  = STAT_AOK;
                    rd_ok_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            err_q   <= 1'b0;
            stat_q  <= STAT_AOK;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
            stat_q  <= stat_d;
            rd_ok_q <= rd_ok_d;
        end
    end

    y86_dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (req_q.addr[AW-1:0]),
        .wdata_i (req_q.wdata),
        .rdata_o (arr_rdata)
    );

    assign req_ready  = rst_n && (state_q == ST_IDLE) && !flush;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rd_ok_q ? arr_rdata : 64'd0;
    assign resp_err   = err_q;
    assign resp_stat  = stat_q;

endmodule
`default_nettype wire

// File: tb/tb_y86_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_y86_dmem_responder
// Purpose : Directed plus randomized bench for y86_dmem_responder against an
//           array-based reference model of the memory.
// Rev     : 1.0  initial release
// ============================================================================
module tb_y86_dmem_responder;

    localparam int DEPTH = 4096;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [2:0]  resp_stat;

    int checks = 0;
    int errors = 0;

    logic [63:0] model [DEPTH];

    always #5 clk = ~clk;

    y86_dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .resp_stat  (resp_stat)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory semantics straight from the rules: in range -> access, else ADR with zero data.
    task automatic model_access(input logic w, input logic [63:0] a, input logic [63:0] d,
                                output logic [63:0] er, output logic ee, output logic [2:0] es);
        if (a < 64'(DEPTH)) begin
            ee = 1'b0;
            es = 3'b000;
            er = w ? 64'd0 : model[a[11:0]];
            if (w) model[a[11:0]] = d;
        end else begin
            ee = 1'b1;
            es = 3'b010;
            er = 64'd0;
        end
    endtask

    task automatic send(input logic w, input logic [63:0] a, input logic [63:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        chk("req_ready_before_accept", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic await_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic transact(input logic w, input logic [63:0] a, input logic [63:0] d,
                            input int stall);
        int          lat;
        logic [63:0] er;
        logic        ee;
        logic [2:0]  es;
        send(w, a, d);
        chk("req_ready_in_wait", 64'(req_ready), 64'd0);
        await_resp(lat);
        chk("latency", 64'(lat), 64'(LAT));
        model_access(w, a, d, er, ee, es);
        chk("rdata", resp_rdata, er);
        chk("err", 64'(resp_err), 64'(ee));
        chk("stat", 64'(resp_stat), 64'(es));
        if (stall > 0) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 64'd0;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk);
                #1;
                chk("hold_valid", 64'(resp_valid), 64'd1);
                chk("hold_rdata", resp_rdata, er);
                chk("hold_err", 64'(resp_err), 64'(ee));
                chk("probe_not_ready", 64'(req_ready), 64'd0);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        chk("valid_after_hs", 64'(resp_valid), 64'd0);
        chk("ready_after_hs", 64'(req_ready), 64'd1);
    endtask

    initial begin
        int          lat;
        logic [63:0] er;
        logic        ee;
        logic [2:0]  es;
        logic [63:0] a;
        int          sel;

        for (int i = 0; i < DEPTH; i++) model[i] = 64'(i + 1);

        rst_n      = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_resp_stat", 64'(resp_stat), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("req_ready_after_release", 64'(req_ready), 64'd1);

        transact(1'b0, 64'd5, 64'd0, 0);
        transact(1'b1, 64'd4095, -64'sd7, 2);
        transact(1'b0, 64'd4095, 64'd0, 0);
        transact(1'b0, 64'd4096, 64'd0, 0);
        transact(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF, 1);
        transact(1'b0, 64'd0, 64'd0, 0);
        transact(1'b0, 64'd4095, 64'd0, 5);

        // Flush while waiting: write must not land.
        send(1'b1, 64'd10, 64'd99);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_idle_blocks_ready", 64'(req_ready), 64'd0);
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("flush_wait_no_resp", 64'(resp_valid), 64'd0);
        end
        transact(1'b0, 64'd10, 64'd0, 0);

        // Flush in RESP: response dropped, write already committed.
        send(1'b1, 64'd10, 64'd99);
        await_resp(lat);
        chk("flush_resp_latency", 64'(lat), 64'(LAT));
        model_access(1'b1, 64'd10, 64'd99, er, ee, es);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_resp_dropped", 64'(resp_valid), 64'd0);
        transact(1'b0, 64'd10, 64'd0, 0);

        // Reset while waiting cancels the pending write.
        send(1'b1, 64'd20, 64'd5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_wait_no_resp", 64'(resp_valid), 64'd0);
        transact(1'b0, 64'd20, 64'd0, 0);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0:       a = {32'($urandom) | 32'h8000_0000, 32'($urandom)};
                1:       a = 64'(DEPTH + $urandom_range(0, 15));
                2:       a = 64'($urandom_range(0, DEPTH - 1));
                default: a = 64'($urandom_range(0, 15)) + 64'(DEPTH - 16);
            endcase
            transact(1'($urandom_range(0, 1)), a, {32'($urandom), 32'($urandom)},
                     $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
